// File: rtl/breath_multi_ramp_pkg.sv
// -----------------------------------------------------------------------------
// breath_multi_ramp_pkg
// Shared definitions for the multi-channel breathing ramp generator:
//   mode_e  - 2-bit per-channel waveform mode as presented on the MODE port
//   state_e - per-channel ramp FSM state
// -----------------------------------------------------------------------------
package breath_multi_ramp_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_TRIANGLE = 2'd1,
    MODE_SAW      = 2'd2,
    MODE_ONESHOT  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_UP   = 2'd0,
    ST_DOWN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/breath_multi_ramp_channel.sv
// -----------------------------------------------------------------------------
// breath_channel
// One ramp channel: step prescaler, UP/DOWN/DONE FSM, clamped LEVEL and PEAK.
// Ports:
//   i_clk       system clock (posedge)
//   i_rst_n     asynchronous active-low reset
//   i_en        enable; 0 freezes prescaler, state and level
//   i_mode      waveform mode (OFF/TRIANGLE/SAW/ONESHOT)
//   i_step_div  prescaler terminal count; level steps every i_step_div+1 cycles
//   i_max       ramp ceiling
//   o_level     registered ramp value
//   o_peak      registered one-cycle pulse when an UP step lands on i_max
// -----------------------------------------------------------------------------
module breath_channel
  import breath_multi_ramp_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DIV_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic [1:0]           i_mode,
  input  logic [DIV_WIDTH-1:0] i_step_div,
  input  logic [WIDTH-1:0]     i_max,
  output logic [WIDTH-1:0]     o_level,
  output logic                 o_peak
);

  mode_e                r_prev_mode;
  state_e               r_state;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0]     r_level;
  logic                 r_peak;

  mode_e                w_mode;
  logic                 w_mode_chg;
  logic [WIDTH-1:0]     w_level_inc;

  assign w_mode      = mode_e'(i_mode);
  assign w_mode_chg  = (w_mode != r_prev_mode);
  assign w_level_inc = r_level + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev_mode <= MODE_OFF;
      r_state     <= ST_UP;
      r_cnt       <= '0;
      r_level     <= '0;
      r_peak      <= 1'b0;
    end else begin
      r_prev_mode <= w_mode;
      r_peak      <= 1'b0;
      if (w_mode == MODE_OFF) begin
        r_state <= ST_UP;
        r_cnt   <= '0;
        r_level <= '0;
      end else if (w_mode_chg) begin
        // A mode change restarts the ramp phase but keeps the current level.
        r_state <= ST_UP;
        r_cnt   <= '0;
      end else if (i_en) begin
        if (r_cnt == i_step_div) begin
          r_cnt <= '0;
          case (r_state)
            ST_UP: begin
              if (r_level < i_max) begin
                r_level <= w_level_inc;
                // SAW marks the reach step; TRIANGLE/ONESHOT mark the hold step
                // below, so each waveform produces one PEAK per period.
                r_peak  <= (w_mode == MODE_SAW) && (w_level_inc == i_max);
              end else begin
                case (w_mode)
                  MODE_TRIANGLE: begin
                    r_level <= i_max;
                    r_state <= ST_DOWN;
                    r_peak  <= 1'b1;
                  end
                  MODE_ONESHOT: begin
                    r_level <= i_max;
                    r_state <= ST_DONE;
                    r_peak  <= 1'b1;
                  end
                  default: begin
                    // SAW: a level left above a lowered ceiling is clamped first,
                    // the wrap to zero happens on the following step.
                    if (r_level > i_max) begin
                      r_level <= i_max;
                      r_peak  <= 1'b1;
                    end else begin
                      r_level <= '0;
                      r_peak  <= (i_max == '0);
                    end
                  end
                endcase
              end
            end
            ST_DOWN: begin
              if (r_level > i_max) begin
                r_level <= i_max;
              end else if (r_level != '0) begin
                r_level <= r_level - 1'b1;
              end else begin
                r_state <= ST_UP;
              end
            end
            ST_DONE: begin
              r_level <= i_max;
            end
            default: begin
              r_state <= ST_UP;
            end
          endcase
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_level = r_level;
  assign o_peak  = r_peak;

endmodule

// File: rtl/breath_multi_ramp.sv
// -----------------------------------------------------------------------------
// breath_multi_ramp
// CHANNELS independent clamped breathing ramps with per-channel PWM outputs
// driven from one shared free-running PWM counter.
// Ports:
//   CLK       system clock (posedge)
//   NRST      asynchronous active-low reset
//   EN        per-channel enable
//   MODE      per-channel mode, channel i at [2i+1:2i]
//   STEP_DIV  per-channel prescaler terminal count, DIV_WIDTH bits each
//   MAX       per-channel ramp ceiling, WIDTH bits each
//   LEVEL     registered ramp value per channel, WIDTH bits each
//   PWM       registered PWM output per channel (LEVEL > pwm counter)
//   PEAK      one-cycle pulse per channel when its ramp peaks at MAX
// -----------------------------------------------------------------------------
module breath_multi_ramp
  import breath_multi_ramp_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DIV_WIDTH = 32
) (
  input  logic                          CLK,
  input  logic                          NRST,
  input  logic [CHANNELS-1:0]           EN,
  input  logic [2*CHANNELS-1:0]         MODE,
  input  logic [DIV_WIDTH*CHANNELS-1:0] STEP_DIV,
  input  logic [WIDTH*CHANNELS-1:0]     MAX,
  output logic [WIDTH*CHANNELS-1:0]     LEVEL,
  output logic [CHANNELS-1:0]           PWM,
  output logic [CHANNELS-1:0]           PEAK
);

  logic [WIDTH*CHANNELS-1:0] w_level;
  logic [WIDTH-1:0]          r_pwm_cnt;
  logic [CHANNELS-1:0]       r_pwm;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    breath_channel #(
      .WIDTH    (WIDTH),
      .DIV_WIDTH(DIV_WIDTH)
    ) u_ch (
      .i_clk     (CLK),
      .i_rst_n   (NRST),
      .i_en      (EN[g]),
      .i_mode    (MODE[2*g +: 2]),
      .i_step_div(STEP_DIV[g*DIV_WIDTH +: DIV_WIDTH]),
      .i_max     (MAX[g*WIDTH +: WIDTH]),
      .o_level   (w_level[g*WIDTH +: WIDTH]),
      .o_peak    (PEAK[g])
    );
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_pwm_cnt <= '0;
      r_pwm     <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_pwm[i] <= (w_level[i*WIDTH +: WIDTH] > r_pwm_cnt);
      end
    end
  end

  assign LEVEL = w_level;
  assign PWM   = r_pwm;

endmodule

// File: tb/tb_breath_multi_ramp.sv
module tb_breath_multi_ramp;
  localparam int CH = 4;
  localparam int W  = 4;
  localparam int DW = 32;

  logic                CLK = 1'b0;
  logic                NRST;
  logic [CH-1:0]       EN;
  logic [2*CH-1:0]     MODE;
  logic [DW*CH-1:0]    STEP_DIV;
  logic [W*CH-1:0]     MAX;
  logic [W*CH-1:0]     LEVEL;
  logic [CH-1:0]       PWM;
  logic [CH-1:0]       PEAK;

  int errors = 0;
  int checks = 0;

  breath_multi_ramp #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .DIV_WIDTH(DW)
  ) dut (
    .CLK     (CLK),
    .NRST    (NRST),
    .EN      (EN),
    .MODE    (MODE),
    .STEP_DIV(STEP_DIV),
    .MAX     (MAX),
    .LEVEL   (LEVEL),
    .PWM     (PWM),
    .PEAK    (PEAK)
  );

  always #5 CLK = ~CLK;

  // Reference model: level as an integer, direction +1 (rising), -1 (falling),
  // 0 (parked at the ceiling).
  int            m_level[CH];
  int            m_dir[CH];
  int            m_prev[CH];
  logic [DW-1:0] m_cnt[CH];
  bit            m_peak[CH];
  bit            m_pwm[CH];
  int            m_pc;

  function automatic int mode_of(int i);
    return int'(MODE[2*i +: 2]);
  endfunction

  function automatic int max_of(int i);
    return int'(MAX[W*i +: W]);
  endfunction

  function automatic int lvl(int i);
    return int'(LEVEL[W*i +: W]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_level[i] = 0;
      m_dir[i]   = 1;
      m_prev[i]  = 0;
      m_cnt[i]   = '0;
      m_peak[i]  = 1'b0;
      m_pwm[i]   = 1'b0;
    end
    m_pc = 0;
  endtask

  task automatic model_eval();
    for (int i = 0; i < CH; i++) begin
      int md;
      int mx;
      logic [DW-1:0] dv;
      md = mode_of(i);
      mx = max_of(i);
      dv = STEP_DIV[DW*i +: DW];
      m_pwm[i]  = (m_level[i] > m_pc);
      m_peak[i] = 1'b0;
      if (md == 0) begin
        m_level[i] = 0;
        m_dir[i]   = 1;
        m_cnt[i]   = '0;
      end else if (md != m_prev[i]) begin
        m_cnt[i] = '0;
        m_dir[i] = 1;
      end else if (EN[i]) begin
        if (m_cnt[i] != dv) begin
          m_cnt[i] = m_cnt[i] + 1;
        end else begin
          m_cnt[i] = '0;
          if (m_dir[i] == 0) begin
            m_level[i] = mx;
          end else if (m_dir[i] < 0) begin
            if (m_level[i] > mx) m_level[i] = mx;
            else if (m_level[i] > 0) m_level[i] = m_level[i] - 1;
            else m_dir[i] = 1;
          end else if (m_level[i] < mx) begin
            m_level[i] = m_level[i] + 1;
            m_peak[i]  = (md == 2) && (m_level[i] == mx);
          end else begin
            case (md)
              1: begin m_level[i] = mx; m_dir[i] = -1; m_peak[i] = 1'b1; end
              3: begin m_level[i] = mx; m_dir[i] = 0;  m_peak[i] = 1'b1; end
              default: begin
                m_level[i] = (m_level[i] > mx) ? mx : 0;
                m_peak[i]  = (m_level[i] == mx);
              end
            endcase
          end
        end
      end
      m_prev[i] = md;
    end
    m_pc = (m_pc + 1) % (1 << W);
  endtask

  task automatic step();
    @(posedge CLK);
    if (NRST) model_eval();
    else model_reset();
    #1;
  endtask

  task automatic set_ch(int i, int md, logic [DW-1:0] dv, int mx);
    logic [1:0]   m2;
    logic [W-1:0] mw;
    m2 = md[1:0];
    mw = mx[W-1:0];
    MODE[2*i +: 2]      = m2;
    STEP_DIV[DW*i +: DW] = dv;
    MAX[W*i +: W]       = mw;
  endtask

  task automatic all_off();
    MODE = '0;
    EN   = '1;
    step();
  endtask

  task automatic test_reset();
    NRST = 1'b0; EN = '1; MODE = '0; STEP_DIV = '0; MAX = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    checks++; if (LEVEL !== '0) begin errors++; $display("FAIL rst_level got=%h exp=0", LEVEL); end
    checks++; if (PWM !== '0) begin errors++; $display("FAIL rst_pwm got=%b exp=0", PWM); end
    checks++; if (PEAK !== '0) begin errors++; $display("FAIL rst_peak got=%b exp=0", PEAK); end
    NRST = 1'b1;
    set_ch(0, 1, '0, 15);
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (lvl(0) !== k) begin errors++; $display("FAIL rst_ramp k=%0d got=%0d exp=%0d", k, lvl(0), k); end
    end
    #2 NRST = 1'b0;
    #1;
    checks++; if (LEVEL !== '0) begin errors++; $display("FAIL async_level got=%h exp=0", LEVEL); end
    checks++; if (PWM !== '0) begin errors++; $display("FAIL async_pwm got=%b exp=0", PWM); end
    checks++; if (PEAK !== '0) begin errors++; $display("FAIL async_peak got=%b exp=0", PEAK); end
    model_reset();
    @(negedge CLK);
    NRST = 1'b1;
    step();
    checks++; if (lvl(0) !== 0) begin errors++; $display("FAIL post_rst_e1 got=%0d exp=0", lvl(0)); end
    step();
    checks++; if (lvl(0) !== 1) begin errors++; $display("FAIL post_rst_e2 got=%0d exp=1", lvl(0)); end
    all_off();
  endtask

  task automatic test_triangle();
    int exp_l[26];
    exp_l = '{0,0,1,1,2,2,3,3,3,3,2,2,1,1,0,0,0,0,1,1,2,2,3,3,3,3};
    set_ch(0, 1, 1, 3);
    for (int k = 0; k < 26; k++) begin
      logic ep;
      step();
      ep = (k == 8) || (k == 24);
      checks++; if (lvl(0) !== exp_l[k]) begin errors++; $display("FAIL tri_level k=%0d got=%0d exp=%0d", k, lvl(0), exp_l[k]); end
      checks++; if (PEAK[0] !== ep) begin errors++; $display("FAIL tri_peak k=%0d got=%b exp=%b", k, PEAK[0], ep); end
    end
    all_off();
  endtask

  task automatic test_saw_oneshot();
    int exp_s[8];
    int exp_o[8];
    exp_s = '{0,1,2,0,1,2,0,1};
    exp_o = '{0,1,2,2,2,2,2,2};
    set_ch(0, 2, '0, 2);
    set_ch(1, 3, '0, 2);
    for (int k = 0; k < 8; k++) begin
      logic eps, epo;
      step();
      eps = (k == 2) || (k == 5);
      epo = (k == 3);
      checks++; if (lvl(0) !== exp_s[k]) begin errors++; $display("FAIL saw_level k=%0d got=%0d exp=%0d", k, lvl(0), exp_s[k]); end
      checks++; if (PEAK[0] !== eps) begin errors++; $display("FAIL saw_peak k=%0d got=%b exp=%b", k, PEAK[0], eps); end
      checks++; if (lvl(1) !== exp_o[k]) begin errors++; $display("FAIL one_level k=%0d got=%0d exp=%0d", k, lvl(1), exp_o[k]); end
      checks++; if (PEAK[1] !== epo) begin errors++; $display("FAIL one_peak k=%0d got=%b exp=%b", k, PEAK[1], epo); end
    end
    set_ch(1, 0, '0, 2);
    step();
    checks++; if (lvl(1) !== 0) begin errors++; $display("FAIL off_clear got=%0d exp=0", lvl(1)); end
    all_off();
  endtask

  task automatic test_max_lower();
    set_ch(0, 1, '0, 15);
    set_ch(1, 2, '0, 15);
    repeat (11) step();
    checks++; if (lvl(0) !== 10 || lvl(1) !== 10) begin errors++; $display("FAIL lower_pre got=%0d,%0d exp=10,10", lvl(0), lvl(1)); end
    set_ch(0, 1, '0, 4);
    set_ch(1, 2, '0, 4);
    step();
    checks++; if (lvl(0) !== 4 || lvl(1) !== 4) begin errors++; $display("FAIL lower_clamp got=%0d,%0d exp=4,4", lvl(0), lvl(1)); end
    checks++; if (PEAK[1:0] !== 2'b11) begin errors++; $display("FAIL lower_peak got=%b exp=11", PEAK[1:0]); end
    for (int k = 0; k < 24; k++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (lvl(i) > 4 || lvl(i) !== m_level[i]) begin
          errors++; $display("FAIL lower_track k=%0d ch=%0d got=%0d exp=%0d", k, i, lvl(i), m_level[i]);
        end
      end
    end
    all_off();
  endtask

  task automatic test_enable();
    int held;
    for (int i = 0; i < CH; i++) set_ch(i, 1, i, 15);
    EN = '1;
    repeat (10) step();
    EN[1] = 1'b0;
    held = lvl(1);
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (lvl(1) !== held) begin errors++; $display("FAIL en_freeze k=%0d got=%0d exp=%0d", k, lvl(1), held); end
      for (int i = 0; i < CH; i++) begin
        checks++; if (lvl(i) !== m_level[i]) begin errors++; $display("FAIL en_indep k=%0d ch=%0d got=%0d exp=%0d", k, i, lvl(i), m_level[i]); end
      end
    end
    EN[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      for (int i = 0; i < CH; i++) begin
        checks++; if (lvl(i) !== m_level[i]) begin errors++; $display("FAIL en_resume k=%0d ch=%0d got=%0d exp=%0d", k, i, lvl(i), m_level[i]); end
      end
    end
    set_ch(2, 1, '1, 15);
    held = lvl(2);
    for (int k = 0; k < 40; k++) begin
      step();
      checks++; if (lvl(2) !== held || lvl(2) !== m_level[2]) begin errors++; $display("FAIL bigdiv k=%0d got=%0d exp=%0d", k, lvl(2), held); end
    end
    all_off();
  endtask

  task automatic test_pwm();
    int highs;
    highs = 0;
    set_ch(0, 3, '0, 4);
    set_ch(1, 0, '0, 0);
    repeat (8) step();
    for (int k = 0; k < 32; k++) begin
      step();
      if (PWM[0] === 1'b1) highs++;
      checks++; if (PWM[0] !== m_pwm[0]) begin errors++; $display("FAIL pwm_ch0 k=%0d got=%b exp=%b", k, PWM[0], m_pwm[0]); end
      checks++; if (PWM[1] !== 1'b0) begin errors++; $display("FAIL pwm_zero k=%0d got=%b exp=0", k, PWM[1]); end
    end
    checks++; if (highs !== 8) begin errors++; $display("FAIL pwm_duty got=%0d exp=8", highs); end
    checks++; if (lvl(0) !== 4) begin errors++; $display("FAIL pwm_level got=%0d exp=4", lvl(0)); end
    all_off();
  endtask

  task automatic test_random();
    for (int i = 0; i < CH; i++) set_ch(i, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 15));
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < CH; i++) begin
        EN[i] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) MODE[2*i +: 2] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) MAX[W*i +: W] = W'($urandom_range(0, 15));
        if ($urandom_range(0, 31) == 0) STEP_DIV[DW*i +: DW] = DW'($urandom_range(0, 2));
      end
      step();
      for (int i = 0; i < CH; i++) begin
        checks++; if (lvl(i) !== m_level[i]) begin errors++; $display("FAIL rnd_level k=%0d ch=%0d got=%0d exp=%0d", k, i, lvl(i), m_level[i]); end
        checks++; if (PEAK[i] !== m_peak[i]) begin errors++; $display("FAIL rnd_peak k=%0d ch=%0d got=%b exp=%b", k, i, PEAK[i], m_peak[i]); end
        checks++; if (PWM[i] !== m_pwm[i]) begin errors++; $display("FAIL rnd_pwm k=%0d ch=%0d got=%b exp=%b", k, i, PWM[i], m_pwm[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_triangle();
    test_saw_oneshot();
    test_max_lower();
    test_enable();
    test_pwm();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
